// File: rtl/ram_dp_be.sv
// ram_dp_be: on-chip RAM with one byte-lane-masked write port, two registered
// read ports, a compile-time read-during-write policy and a sequential clear
// engine that zero-fills the array one word per cycle.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   reset             synchronous active-high reset; restarts the clear engine
//   clear             request a full zero-fill (honoured only when idle)
//   busy              high while the clear engine runs; reads/writes ignored
//   we, wa, be, data  write port; be[i] enables data[i*lane_size +: lane_size]
//   re0, ra0          read port 0 request
//   result0, valid0   read port 0 data (latency 1); valid0 marks a fresh update
//   re1, ra1          read port 1 request
//   result1, valid1   read port 1 data (latency 1); valid1 marks a fresh update
//   state_dbg         1 while the clear engine is active (CLEAR state)
//
// Request semantics: a read or write is taken on any rising edge where its
// enable is high, busy is low and clear is low. There is no back-pressure; a
// taken read always produces result_k/valid_k on the following edge.
module ram_dp_be #(
  parameter int addr_size = 4,
  parameter int cell_size = 16,
  parameter int lane_size = 8,
  parameter int size      = 2 ** addr_size,
  parameter bit bypass    = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  output logic                           busy,
  input  logic                           we,
  input  logic [addr_size-1:0]           wa,
  input  logic [cell_size/lane_size-1:0] be,
  input  logic [cell_size-1:0]           data,
  input  logic                           re0,
  input  logic [addr_size-1:0]           ra0,
  output logic [cell_size-1:0]           result0,
  output logic                           valid0,
  input  logic                           re1,
  input  logic [addr_size-1:0]           ra1,
  output logic [cell_size-1:0]           result1,
  output logic                           valid1,
  output logic                           state_dbg
);

  localparam int lanes = cell_size / lane_size;
  localparam logic [addr_size-1:0] last_ptr = addr_size'(size - 1);

  generate
    if (cell_size % lane_size != 0) begin : g_bad_lane
      $error("ram_dp_be: cell_size must be a multiple of lane_size");
    end
    if (size > 2 ** addr_size || size < 1) begin : g_bad_size
      $error("ram_dp_be: size must be in 1 .. 2**addr_size");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               state;
  logic [addr_size-1:0] ptr;
  logic [cell_size-1:0] ram [size];

  logic [cell_size-1:0] lane_mask;
  logic                 wr_ok;
  logic [cell_size-1:0] rd0_old, rd1_old;
  logic [cell_size-1:0] rd0_next, rd1_next;

  assign state_dbg = (state == ST_CLEAR);

  // Addresses beyond the populated depth are treated as absent words.
  function automatic logic in_range(input logic [addr_size-1:0] a);
    return {1'b0, a} < (addr_size + 1)'(size);
  endfunction

  // Expand per-lane enables into a per-bit mask.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < lanes; i++) begin
      lane_mask[i*lane_size +: lane_size] = {lane_size{be[i]}};
    end
  end

  assign wr_ok = we && in_range(wa);

  // Read data selection. On an address collision with write-first policy the
  // enabled lanes are forwarded from the write data, the rest from the array.
  always_comb begin
    rd0_old  = in_range(ra0) ? ram[ra0] : '0;
    rd1_old  = in_range(ra1) ? ram[ra1] : '0;
    rd0_next = rd0_old;
    rd1_next = rd1_old;
    if (bypass && wr_ok && (ra0 == wa)) begin
      rd0_next = (rd0_old & ~lane_mask) | (data & lane_mask);
    end
    if (bypass && wr_ok && (ra1 == wa)) begin
      rd1_next = (rd1_old & ~lane_mask) | (data & lane_mask);
    end
  end

  // Control FSM and registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      ptr     <= '0;
      busy    <= 1'b1;
      result0 <= '0;
      result1 <= '0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          valid0 <= 1'b0;
          valid1 <= 1'b0;
          ptr    <= ptr + 1'b1;
          if (ptr == last_ptr) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (clear) begin
            state  <= ST_CLEAR;
            ptr    <= '0;
            busy   <= 1'b1;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
          end else begin
            valid0 <= re0;
            valid1 <= re1;
            if (re0) result0 <= rd0_next;
            if (re1) result1 <= rd1_next;
          end
        end
      endcase
    end
  end

  // Storage array: no reset so it can map onto block RAM. The clear engine
  // owns the write port while active; a clear request blocks a same-edge write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram[ptr] <= '0;
      end else if (!clear && wr_ok) begin
        for (int i = 0; i < lanes; i++) begin
          if (be[i]) ram[wa][i*lane_size +: lane_size] <= data[i*lane_size +: lane_size];
        end
      end
    end
  end

endmodule
